// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared playfield constants and AI paddle state encodings
package pong_pkg;

  localparam int COORD_W     = 13;
  localparam int FIELD_H     = 1920;
  localparam int PADDLE_STEP = 16;

  localparam logic [1:0] AI_IDLE   = 2'd0;
  localparam logic [1:0] AI_CENTER = 2'd1;
  localparam logic [1:0] AI_TRACK  = 2'd2;
  localparam logic [1:0] AI_WAIT   = 2'd3;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'hACE1;
    end else if (step) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/paddle_ai_ctrl.sv
// rtl/paddle_ai_ctrl.sv - computer-opponent paddle command generator; PADDLE_AI_JITTER_EN adds LFSR target jitter
module paddle_ai_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD_H     = pong_pkg::FIELD_H,
  parameter int DEADBAND    = pong_pkg::PADDLE_STEP,
  parameter int REACT_TICKS = 4,
  parameter int SIDE        = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [12:0] ball_y,
  input  logic        ball_dx_neg,
  input  logic [12:0] paddle_y,
  input  logic [12:0] paddle_size,
  output logic        move_up,
  output logic        move_down,
  output logic [1:0]  state_out
);

  localparam logic [13:0] FH14       = 14'(FIELD_H);
  localparam logic [13:0] DB14       = 14'(DEADBAND);
  localparam logic [7:0]  REACT_INIT = (REACT_TICKS > 0) ? 8'(REACT_TICKS - 1) : 8'd0;

  logic [1:0]  state;
  logic [7:0]  react_cnt;
  logic        approach;
  logic        approach_q;
  logic        flip;
  logic [13:0] track_tgt;
  logic [13:0] target;
  logic [13:0] pad14;
  logic [13:0] size14;
  logic        want_up;
  logic        want_down;

  assign approach = (SIDE == 0) ? ball_dx_neg : ~ball_dx_neg;
  assign flip     = approach != approach_q;

`ifdef PADDLE_AI_JITTER_EN
  localparam logic signed [15:0] FH_S = 16'(FIELD_H);

  logic [15:0]        lfsr_value;
  logic signed [15:0] jit_sum;
  logic               jitter_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (frame_tick),
    .value (lfsr_value)
  );

  assign jitter_unused = ^lfsr_value[15:6];
  assign jit_sum = $signed({3'b000, ball_y}) + $signed({10'd0, lfsr_value[5:0]}) - 16'sd32;

  // Offset can push the target outside the field; saturate so clamp logic stays meaningful
  always_comb begin
    track_tgt = jit_sum[13:0];
    if (jit_sum < 16'sd0) begin
      track_tgt = 14'd0;
    end else if (jit_sum > FH_S) begin
      track_tgt = FH14;
    end
  end
`else
  assign track_tgt = {1'b0, ball_y};
`endif

  assign target = (state == AI_TRACK) ? track_tgt : (FH14 >> 1);
  assign pad14  = {1'b0, paddle_y};
  assign size14 = {1'b0, paddle_size};

  // Bottom clamp written as pad+size >= FIELD_H so an oversized paddle_size cannot underflow
  assign want_down = (pad14 + DB14 < target) && !(pad14 + size14 >= FH14);
  assign want_up   = (pad14 > target + DB14) && !(pad14 <= size14);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AI_IDLE;
      react_cnt  <= 8'd0;
      approach_q <= 1'b0;
      move_up    <= 1'b0;
      move_down  <= 1'b0;
    end else begin
      move_up   <= 1'b0;
      move_down <= 1'b0;
      if (frame_tick) begin
        approach_q <= approach;
      end
      if (!enable) begin
        state <= AI_IDLE;
      end else begin
        case (state)
          AI_IDLE: state <= approach ? AI_TRACK : AI_CENTER;
          AI_CENTER, AI_TRACK: begin
            if (frame_tick) begin
              if (flip) begin
                if (REACT_TICKS > 0) begin
                  state     <= AI_WAIT;
                  react_cnt <= REACT_INIT;
                end else begin
                  state <= approach ? AI_TRACK : AI_CENTER;
                end
              end else begin
                move_up   <= want_up;
                move_down <= want_down;
              end
            end
          end
          default: begin
            if (frame_tick) begin
              if (flip) begin
                react_cnt <= REACT_INIT;
              end else if (react_cnt == 8'd0) begin
                state <= approach ? AI_TRACK : AI_CENTER;
              end else begin
                react_cnt <= react_cnt - 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_paddle_ai_ctrl.sv
// tb/tb_paddle_ai_ctrl.sv - scoreboard bench for paddle_ai_ctrl (jitter vectors when PADDLE_AI_JITTER_EN)
module tb_paddle_ai_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [12:0] ball_y = 13'd0;
  logic        ball_dx_neg = 1'b0;
  logic [12:0] paddle_y = 13'd500;
  logic [12:0] paddle_size = 13'd100;
  logic        move_up;
  logic        move_down;
  logic [1:0]  state_out;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic [1:0] st;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        tick_seen = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  paddle_ai_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .ball_y      (ball_y),
    .ball_dx_neg (ball_dx_neg),
    .paddle_y    (paddle_y),
    .paddle_size (paddle_size),
    .move_up     (move_up),
    .move_down   (move_down),
    .state_out   (state_out)
  );

  always @(posedge clk) tick_seen <= frame_tick;

  always @(negedge clk) begin
    if (tick_seen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: output cycle with no expected entry at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({move_up, move_down, state_out} !== mon_e) begin
          n_fail++;
          $display("FAIL tick_cmd: got up=%0d down=%0d state=%0d, want up=%0d down=%0d state=%0d at %0t",
                   move_up, move_down, state_out, mon_e.up, mon_e.dn, mon_e.st, $time);
        end
      end
    end else begin
      n_checks++;
      if (move_up !== 1'b0 || move_down !== 1'b0) begin
        n_fail++;
        $display("FAIL quiet_cmd: got up=%0d down=%0d, want 0 0 at %0t", move_up, move_down, $time);
      end
    end
  end

  task automatic check_state(input logic [1:0] want, input string name);
    n_checks++;
    if (state_out !== want) begin
      n_fail++;
      $display("FAIL %s: state_out=%0d want %0d", name, state_out, want);
    end
  endtask

  function automatic exp_t jit_expect(input logic [15:0] lf);
    int t;
    exp_t e;
    t = int'(ball_y) + int'(lf[5:0]) - 32;
    if (t < 0) t = 0;
    if (t > 1920) t = 1920;
    e.up = (int'(paddle_y) > t + 16) && (paddle_y > paddle_size);
    e.dn = (int'(paddle_y) + 16 < t) && (int'(paddle_y) + int'(paddle_size) < 1920);
    e.st = 2'd2;
    return e;
  endfunction

  task automatic issue_tick(input exp_t e);
    frame_tick = 1'b1;
    exp_q.push_back(e);
    if (rst) m_lfsr = 16'hACE1;
    else m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick(input logic up, input logic dn, input logic [1:0] st);
    exp_t e;
    e.up = up;
    e.dn = dn;
    e.st = st;
    issue_tick(e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_state(2'd0, "reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_state(2'd0, "idle_disabled");
    enable = 1'b1;
    @(negedge clk);
    check_state(2'd1, "enable_center");

    paddle_y = 13'd500;  tick(1'b0, 1'b1, 2'd1);
    paddle_y = 13'd960;  tick(1'b0, 1'b0, 2'd1);
    paddle_y = 13'd976;  tick(1'b0, 1'b0, 2'd1);
    paddle_y = 13'd977;  tick(1'b1, 1'b0, 2'd1);

    ball_y = 13'd300;
    ball_dx_neg = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 2'd3);
    tick(1'b0, 1'b0, 2'd2);

    paddle_y = 13'd800;
    repeat (3) tick(1'b1, 1'b0, 2'd2);

    ball_y = 13'd0;     paddle_y = 13'd100;  tick(1'b0, 1'b0, 2'd2);
    paddle_y = 13'd101;                      tick(1'b1, 1'b0, 2'd2);
    ball_y = 13'd1920;  paddle_y = 13'd1820; tick(1'b0, 1'b0, 2'd2);
    paddle_y = 13'd1819;                     tick(1'b0, 1'b1, 2'd2);

    ball_dx_neg = 1'b0;  tick(1'b0, 1'b0, 2'd3);
    ball_dx_neg = 1'b1;  tick(1'b0, 1'b0, 2'd3);
    repeat (3) tick(1'b0, 1'b0, 2'd3);
    tick(1'b0, 1'b0, 2'd2);
    tick(1'b0, 1'b1, 2'd2);

    enable = 1'b0;
    tick(1'b0, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 2'd0);

    enable = 1'b1;
    @(negedge clk);
    check_state(2'd2, "reenable_track");
    rst = 1'b1;
    tick(1'b0, 1'b0, 2'd0);
    check_state(2'd0, "mid_reset");
    rst = 1'b0;

`ifdef PADDLE_AI_JITTER_EN
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    m_lfsr = 16'hACE1;
    rst = 1'b0;
    ball_dx_neg = 1'b1;
    tick(1'b0, 1'b0, 2'd0);
    enable = 1'b1;
    @(negedge clk);
    check_state(2'd2, "jitter_track");
    ball_y = 13'd1000;
    paddle_y = 13'd1000;
    paddle_size = 13'd100;
    for (int i = 0; i < 64; i++) begin
      issue_tick(jit_expect(m_lfsr));
    end
`endif

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
